// File: rtl/mem_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_responder_if
//  Description : Request/response bundle between a memory initiator and the
//                on-chip memory responder.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_responder_if;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic        rd_i;
    logic        we_i;
    logic [31:0] data_o;
    logic        ack_o;
    logic        err_o;

    modport master (
        output addr_i, data_i, rd_i, we_i,
        input  data_o, ack_o, err_o
    );

    modport slave (
        input  addr_i, data_i, rd_i, we_i,
        output data_o, ack_o, err_o
    );
endinterface
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : mem_responder
//  Description : Word-addressed on-chip memory slave with programmable wait
//                states, one-cycle ack pulse and error flag on illegal access.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_responder #(
    parameter int          DEPTH_LOG2  = 10,
    parameter logic [31:0] BASE        = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 2
) (
    input  wire logic          clk,
    input  wire logic          rst,
    mem_responder_if.slave     bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2,
        S_TURN = 2'd3
    } state_t;

    // Upper bound kept at 33 bits so a window ending at 4 GiB does not wrap.
    localparam logic [32:0] C_LIMIT = {1'b0, BASE} + (33'd4 << DEPTH_LOG2);
    localparam logic [3:0]  C_WAIT  = 4'(WAIT_CYCLES);

    logic [31:0] mem [2**DEPTH_LOG2];

    state_t      state_q, state_d;
    logic [3:0]  cnt_q,   cnt_d;
    logic [31:0] addr_q,  addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        rd_q,    rd_d;
    logic        we_q,    we_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ack_q,   ack_d;
    logic        err_q,   err_d;

    logic [31:0]           req_addr;
    logic [31:0]           req_wdata;
    logic                  req_rd;
    logic                  req_we;
    logic                  illegal;
    logic [DEPTH_LOG2-1:0] idx;
    logic                  enter_ack;
    logic                  mem_we;

    // With zero wait states the access completes on the sampling edge itself,
    // so the check must see the live inputs rather than the latched copy.
    always_comb begin
        req_addr  = (state_q == S_IDLE) ? bus.addr_i : addr_q;
        req_wdata = (state_q == S_IDLE) ? bus.data_i : wdata_q;
        req_rd    = (state_q == S_IDLE) ? bus.rd_i   : rd_q;
        req_we    = (state_q == S_IDLE) ? bus.we_i   : we_q;
        illegal   = (req_addr[1:0] != 2'b00)
                  || ({1'b0, req_addr} <  {1'b0, BASE})
                  || ({1'b0, req_addr} >= C_LIMIT)
                  || (req_rd && req_we);
        idx       = DEPTH_LOG2'((req_addr - BASE) >> 2);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rd_d      = rd_q;
        we_d      = we_q;
        rdata_d   = rdata_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        enter_ack = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.rd_i || bus.we_i) begin
                    addr_d  = bus.addr_i;
                    wdata_d = bus.data_i;
                    rd_d    = bus.rd_i;
                    we_d    = bus.we_i;
                    cnt_d   = C_WAIT;
                    if (WAIT_CYCLES == 0) begin
                        state_d   = S_ACK;
                        enter_ack = 1'b1;
                    end else begin
                        state_d   = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!bus.rd_i && !bus.we_i) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 4'd1) begin
                    state_d   = S_ACK;
                    cnt_d     = 4'd0;
                    enter_ack = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACK:   state_d = S_TURN;
            default: state_d = S_IDLE;
        endcase

        if (enter_ack) begin
            ack_d = 1'b1;
            if (illegal) begin
                err_d   = 1'b1;
                rdata_d = 32'h0;
            end else if (req_rd) begin
                rdata_d = mem[idx];
            end
        end
    end

    assign mem_we = enter_ack && !illegal && req_we;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rd_q    <= 1'b0;
            we_q    <= 1'b0;
            rdata_q <= 32'h0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    // Storage is deliberately outside the reset domain: contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx] <= req_wdata;
        end
    end

    assign bus.data_o = rdata_q;
    assign bus.ack_o  = ack_q;
    assign bus.err_o  = err_q;

endmodule
`default_nettype wire
